// File: rtl/out_port_arbiter.sv
// Round-robin output-port arbiter with credit flow control and flush/drain.
// Optional per-port grant counters when ARB_STATS_EN is defined.
module out_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [3:0]            req,
    input  logic [3:0][PKT_W-1:0] pkt_in,
    output logic [3:0]            accept,
    output logic [PKT_W-1:0]      pkt_out,
    output logic                  pkt_out_valid,
    input  logic                  credit_ret,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [CW-1:0]         credits,
`ifdef ARB_STATS_EN
    output logic [3:0][15:0]      grant_cnt,
`endif
    output logic                  err_credit
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t        state;
    logic [1:0]    ptr;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;
    logic          grant;
    logic [CW-1:0] eff;
    logic          ret_ok;

    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Flush in the same cycle blocks the grant even though state is still RUN.
    assign grant  = !rst_b && (state == RUN) && !flush
                  && (credits != '0) && found;
    assign accept = grant ? (4'b0001 << win) : 4'b0000;

    assign eff    = credits - CW'(grant);
    assign ret_ok = credit_ret && (eff != FULL);

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state         <= RUN;
            ptr           <= 2'd0;
            credits       <= FULL;
            pkt_out       <= '0;
            pkt_out_valid <= 1'b0;
            flush_done    <= 1'b0;
            err_credit    <= 1'b0;
        end else begin
            credits       <= eff + CW'(ret_ok);
            pkt_out_valid <= grant;
            flush_done    <= 1'b0;
            if (credit_ret && !ret_ok)
                err_credit <= 1'b1;
            if (grant) begin
                pkt_out <= pkt_in[win];
                ptr     <= win + 2'd1;
            end
            unique case (state)
                RUN: begin
                    if (flush)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (credits == FULL) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            grant_cnt <= '0;
        end else if (flush_done) begin
            grant_cnt <= '0;
        end else if (grant && grant_cnt[win] != 16'hFFFF) begin
            grant_cnt[win] <= grant_cnt[win] + 16'd1;
        end
    end
`endif

endmodule
